load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/mips_mem_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: request opcodes, FSM states and small decode helpers.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLh  = 3'd1,
    OpLhu = 3'd2,
    OpLb  = 3'd3,
    OpLbu = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StRmwRead,
    StRmwWrite,
    StResp
  } lsu_state_e;

  function automatic logic is_load(lsu_op_e op);
    return op inside {OpLw, OpLh, OpLhu, OpLb, OpLbu};
  endfunction

  // Word accesses need a 4-byte aligned address, halfword accesses a 2-byte aligned one.
  function automatic logic misaligned(lsu_op_e op, logic [1:0] off);
    logic mis;
    case (op)
      OpLw, OpSw:        mis = |off;
      OpLh, OpLhu, OpSh: mis = off[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling: extracts and extends load data, and merges sub-word store data.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    half_sel = offset[1] ? word[15:0] : word[31:16];
    case (offset)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase

    load_data = word;
    case (op)
      OpLh:    load_data = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_data = {16'h0000, half_sel};
      OpLb:    load_data = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_data = {24'h000000, byte_sel};
      default: load_data = word;
    endcase

    merge_data = word;
    case (op)
      OpSh: merge_data = offset[1] ? {word[31:16], wdata[15:0]} : {wdata[15:0], word[15:0]};
      OpSb: begin
        case (offset)
          2'd0:    merge_data = {wdata[7:0], word[23:0]};
          2'd1:    merge_data = {word[31:24], wdata[7:0], word[15:0]};
          2'd2:    merge_data = {word[31:16], wdata[7:0], word[7:0]};
          default: merge_data = {word[31:8], wdata[7:0]};
        endcase
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide memory with combinational reads;
// sub-word stores are done as read-modify-write. All outputs are registered.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned WORDS = 20,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          mem_read,
  output logic          mem_write
);

  lsu_state_e    state_q, state_d;
  lsu_op_e       op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  lsu_op_e       req_op_e;
  logic [AW-1:0] idx_ext;
  logic          req_err;
  logic [31:0]   load_data;
  logic [31:0]   merge_data;

  assign req_op_e = lsu_op_e'(req_op);
  assign idx_ext  = {2'b00, req_addr[AW-1:2]};
  assign req_err  = misaligned(req_op_e, req_addr[1:0]) || (idx_ext >= AW'(WORDS));

  // Lane logic always sees the live memory word, so both the load result and the
  // RMW merge are captured on the edge that closes the read cycle.
  lsu_lane_align u_lane_align (
    .op         (op_q),
    .offset     (off_q),
    .word       (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d        = req_op_e;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          mem_addr_d  = idx_ext;
          if (req_err) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (is_load(req_op_e)) begin
            state_d    = StRead;
            mem_read_d = 1'b1;
          end else if (req_op_e == OpSw) begin
            state_d     = StWrite;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = StRmwRead;
            mem_read_d = 1'b1;
          end
        end
      end
      StRead: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_data;
      end
      StRmwRead: begin
        state_d     = StRmwWrite;
        mem_write_d = 1'b1;
        mem_wdata_d = merge_data;
      end
      StWrite, StRmwWrite: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      StResp: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = StIdle;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_q         <= OpLw;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached memory, arithmetic reference model, per-cycle compare process.
module tb_load_store_unit;

  localparam int unsigned WORDS = 20;
  localparam int unsigned AW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_read;
  logic          mem_write;

  load_store_unit #(.WORDS(WORDS), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_acc = 0;
  int meas_lat = 0;
  logic got_err;
  logic mem_init_done = 1'b0;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  logic [31:0] exp_rdata, exp_wword, exp_idx;
  logic        exp_err;
  int          exp_lat, exp_reads, exp_writes;

  function automatic logic [31:0] init_word(int i);
    return (i == 3) ? 32'h8899AABB : (32'hA5000000 ^ (32'(i) * 32'h00030507));
  endfunction

  assign mem_rdata = (mem_addr < WORDS) ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init_done) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (reset) begin
      if (mem_read) rd_cnt <= rd_cnt + 1;
      if (mem_write) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_addr < WORDS) mem[mem_addr[4:0]] <= mem_wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference: access size, alignment and range decide errors; lanes are found by shifting.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int size, shift;
    logic [31:0] mask, word;
    size = (op == 3'd0 || op == 3'd5) ? 4 :
           ((op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1);
    exp_idx = addr >> 2;
    exp_err = ((addr % size) != 0) || (exp_idx >= WORDS);
    mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
    shift = (4 - int'(addr % 4) - size) * 8;
    exp_rdata = 32'h0; exp_wword = 32'h0; exp_reads = 0; exp_writes = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (op <= 3'd4) begin
      word = ref_mem[exp_idx[4:0]];
      exp_rdata = (word >> shift) & mask;
      if ((op == 3'd1 || op == 3'd3) && exp_rdata[8*size-1]) exp_rdata = exp_rdata | ~mask;
      exp_lat = 2;
      exp_reads = 1;
    end else begin
      word = ref_mem[exp_idx[4:0]];
      word = (word & ~(mask << shift)) | ((wd & mask) << shift);
      ref_mem[exp_idx[4:0]] = word;
      exp_wword = word;
      exp_writes = 1;
      exp_reads = (op == 3'd5) ? 0 : 1;
      exp_lat = (op == 3'd5) ? 2 : 3;
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] got);
    int acc, r0, w0;
    bit seen;
    model(op, addr, wd);
    r0 = rd_cnt;
    w0 = wr_cnt;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    acc = cyc;
    last_acc = acc;
    @(posedge clk);
    #1;
    // Keep a junk store pending while busy; it must be ignored.
    req_op = 3'd5; req_addr = '0; req_wdata = 32'hDEADBEEF;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = resp_valid;
    end
    req_valid = 1'b0;
    got = resp_rdata;
    got_err = resp_err;
    meas_lat = cyc - acc;
    if (!seen) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(meas_lat), 32'(exp_lat));
      check("read_pulses", 32'(rd_cnt - r0), 32'(exp_reads));
      check("write_pulses", 32'(wr_cnt - w0), 32'(exp_writes));
      resp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check("idle_after_resp", 32'({req_ready, resp_valid}), 32'd2);
    end
  endtask

  // Per-cycle compare against the model's current expectation.
  always @(negedge clk) begin
    if (reset) begin
      check("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (mem_read || mem_write) check("mem_addr", mem_addr, exp_idx);
      if (mem_write) check("mem_wdata", mem_wdata, exp_wword);
      if (resp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(exp_err));
        check("req_ready_busy", 32'(req_ready), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    int a1, w0;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
    exp_idx = 32'h0; exp_wword = 32'h0; exp_rdata = 32'h0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req_ready, resp_valid, resp_err, mem_read, mem_write}), 32'h10);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'd12, 32'h0, 0, g);
    check("lw12_literal", g, 32'h8899AABB);
    check("lw_lat_literal", 32'(meas_lat), 32'd2);
    issue(3'd3, 32'd13, 32'h0, 0, g);
    a1 = last_acc;
    check("lb13_literal", g, 32'hFFFFFF99);
    issue(3'd4, 32'd13, 32'h0, 0, g);
    check("b2b_spacing", 32'(last_acc - a1), 32'd3);
    check("lbu13_literal", g, 32'h00000099);
    issue(3'd1, 32'd14, 32'h0, 0, g);
    check("lh14_literal", g, 32'hFFFFAABB);
    issue(3'd2, 32'd14, 32'h0, 0, g);
    check("lhu14_literal", g, 32'h0000AABB);
    issue(3'd7, 32'd14, 32'h12345677, 0, g);
    check("sb_lat_literal", 32'(meas_lat), 32'd3);
    check("sb_mem_literal", mem[3], 32'h889977BB);

    issue(3'd0, 32'd6, 32'h0, 0, g);
    check("lw6_err_literal", {31'd0, got_err}, 32'd1);
    check("lw6_rdata_literal", g, 32'h0);
    issue(3'd6, 32'd5, 32'h0000BEEF, 0, g);
    check("sh5_err_literal", {31'd0, got_err}, 32'd1);
    issue(3'd0, 32'd80, 32'h0, 0, g);
    check("lw80_err_literal", {31'd0, got_err}, 32'd1);
    issue(3'd0, 32'd76, 32'h0, 0, g);

    issue(3'd0, 32'd12, 32'h0, 4, g);
    check("lw12_hold_literal", g, 32'h889977BB);
    issue(3'd5, 32'd8, 32'hCAFEF00D, 1, g);
    issue(3'd0, 32'd8, 32'h0, 0, g);
    check("sw_lw8_literal", g, 32'hCAFEF00D);
    issue(3'd6, 32'd10, 32'hFFFF1234, 0, g);
    issue(3'd1, 32'd8, 32'h0, 2, g);
    check("lh8_literal", g, 32'hFFFFCAFE);
    issue(3'd3, 32'd11, 32'h0, 0, g);
    check("lb11_literal", g, 32'h00000034);
    issue(3'd7, 32'd16, 32'h000000C3, 0, g);
    issue(3'd4, 32'd16, 32'h0, 0, g);
    check("lbu16_literal", g, 32'h000000C3);

    // Reset in the middle of an SH read-modify-write.
    exp_idx = 32'd3;
    w0 = wr_cnt;
    req_valid = 1'b1; req_op = 3'd6; req_addr = 32'd14; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rmw_read_pulse", 32'(mem_read), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({req_ready, resp_valid, resp_err, mem_read, mem_write}), 32'h10);
    check("rst_mid_rdata", resp_rdata, 32'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    check("rst_mid_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check("rst_not_resumed", 32'({req_ready, resp_valid}), 32'd2);
    issue(3'd0, 32'd12, 32'h0, 0, g);
    check("lw12_after_reset_literal", g, 32'h889977BB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
